vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; the successor to the fixed 640x480 sync generator.
- Adds runtime-reprogrammable timing, applied glitch-free at frame boundaries.
- Adds a pixel-clock enable, configurable sync polarity, a sync/DE delay line to match downstream pixel-pipeline latency, and line/frame start strobes.
- Sits between the pixel clock domain root and the pixel generator/encoder.

Parameters:
- CW, 11, width of x/y counters and timing fields.
- H_ACTIVE, 640, default visible pixels per line.
- H_FP, 16, default horizontal front porch.
- H_SYNC, 96, default hsync width.
- H_BP, 48, default horizontal back porch (must be >=1).
- V_ACTIVE, 480, default visible lines.
- V_FP, 10, default vertical front porch.
- V_SYNC, 2, default vsync width.
- V_BP, 33, default vertical back porch (must be >=1).
- HS_POL, 0, asserted hsync level (0 = active-low).
- VS_POL, 0, asserted vsync level.
- DELAY, 2, pix_en-qualified stages between x/y and hsync/vsync/de (0..15).

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel advance enable; state changes only when 1 (except config capture)
- cfg_load  in  1  one-cycle strobe capturing cfg_* into shadow registers
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CW each  new horizontal timing
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CW each  new vertical timing
- cfg_pending  out  1  shadow config waiting for frame wrap
- cfg_err  out  1  one-cycle pulse: cfg_load rejected
- x, y  out  CW each  current raster position
- line_start  out  1  high for the one clk cycle in which x first becomes 0
- frame_start  out  1  high for the one clk cycle in which (x,y) first becomes (0,0)
- hsync, vsync, de  out  1 each  delayed sync/data-enable

Behaviour:
- Live timing set: h_total = a+fp+sync+bp, computed in CW+2 bits; same for v_total.
- Reset (rst_n=0 at clk edge):
  - Live set loads the parameter defaults; shadow is cleared; cfg_pending=0; cfg_err=0.
  - x = H_total-1 and y = V_total-1, so the first pix_en after reset produces (0,0) with frame_start=1.
  - hsync=~HS_POL, vsync=~VS_POL, de=0; all delay stages hold inactive values; line_start=frame_start=0.
- Counter advance (pix_en=1):
  - If x == h_total-1: x=0, and y advances (wrapping to 0 at v_total-1).
  - Otherwise x=x+1.
  - pix_en=0: x, y, delay line, hsync/vsync/de all hold; strobes are 0.
- Decode, undelayed and coherent with x/y in the same cycle:
  - de_raw = x<h_active && y<v_active.
  - hs_raw = h_active+h_fp <= x < h_active+h_fp+h_sync.
  - vs_raw uses the same form vertically and is line-granular (changes with y only).
  - Output level = raw ? POL : ~POL.
- Delay line:
  - hsync/vsync/de equal the decode of the position DELAY pix_en advances earlier.
  - DELAY=0 means same cycle as x/y.
- Strobes: line_start and frame_start are not delayed and are aligned to x/y.
- Config capture (independent of pix_en), on cfg_load=1:
  - Reject, with cfg_err=1 next cycle and shadow/pending unchanged, if any of: active==0, sync==0, bp==0 (either axis), or a total exceeds 2^CW.
  - Otherwise the shadow is overwritten and cfg_pending=1 next cycle.
  - A second load while pending overwrites the shadow (last wins).
- Config apply:
  - On the advance from (h_total-1, v_total-1) to (0,0) with cfg_pending=1, the shadow becomes live and cfg_pending clears on the same edge.
  - The new frame's decode uses the new set.
  - A cfg_load in the same cycle as that wrap is not applied at this wrap; its values stay in shadow, pending stays 1, and they apply at the next wrap.
- Delay-line contents across a config switch are not flushed; the tail of the old frame drains naturally.
- Reset mid-frame or mid-pending discards the shadow and restores the defaults.

Test Plan:
- Small config H=4/1/2/1 (total 8), V=3/1/1/1 (total 6), DELAY=0, pix_en=1:
  - First cycle after reset: (0,0), frame_start=1, de=1.
  - hsync asserted exactly at x=5,6.
  - vsync asserted only for y=4.
  - Frame wraps after 48 cycles.
- DELAY=3, same config: de/hsync/vsync waveforms equal the DELAY=0 run shifted by 3 cycles; x/y unchanged.
- pix_en toggling 1,0,0,1: x advances only on enabled cycles; a strobe never lasts 2 cycles; outputs hold when disabled.
- Load H_ACTIVE=6 mid-frame:
  - cfg_pending=1 until the wrap.
  - Old frame completes with total 8, then the new frame has h_total 10.
  - cfg_pending=0 after the wrap.
- Config edge cases:
  - cfg_load with cfg_h_bp=0 -> cfg_err pulse, pending stays 0.
  - cfg_load coincident with the wrap -> applied one frame later.
- Assert rst_n=0 while pending, mid-line: outputs return to reset values, defaults restored, and the next frame_start follows the first pix_en.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: programmable timing set applied at frame wrap, pixel enable,
// selectable sync polarity, pix_en-qualified sync/DE delay line and line/frame strobes.
module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int DELAY    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          cfg_load,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  output logic          cfg_pending,
  output logic          cfg_err,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          de
);

  localparam int TW = CW + 2;
  localparam logic [TW-1:0] MAX_TOTAL = TW'(2 ** CW);
  localparam logic [CW-1:0] X_RST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] Y_RST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  typedef struct packed {
    logic [CW-1:0] h_active;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] v_active;
    logic [CW-1:0] v_fp;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_bp;
  } timing_t;

  localparam timing_t DEFAULTS = '{
    h_active: CW'(H_ACTIVE), h_fp: CW'(H_FP), h_sync: CW'(H_SYNC), h_bp: CW'(H_BP),
    v_active: CW'(V_ACTIVE), v_fp: CW'(V_FP), v_sync: CW'(V_SYNC), v_bp: CW'(V_BP)
  };

  function automatic logic [TW-1:0] sum4(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c, input logic [CW-1:0] d);
    return TW'(a) + TW'(b) + TW'(c) + TW'(d);
  endfunction

  timing_t       live_q, live_d, shadow_q, shadow_d, cfg_in;
  logic          pending_q, pending_d, err_q, err_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          ls_q, ls_d, fs_q, fs_d;

  logic [TW-1:0] h_total, v_total, cfg_h_total, cfg_v_total;
  logic [TW-1:0] xw, yw, hs_start, vs_start;
  logic          h_end, v_end, cfg_bad;
  logic          de_raw, hs_raw, vs_raw;
  logic          de_del, hs_del, vs_del;

  assign cfg_in = '{
    h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
    v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp
  };

  assign h_total     = sum4(live_q.h_active, live_q.h_fp, live_q.h_sync, live_q.h_bp);
  assign v_total     = sum4(live_q.v_active, live_q.v_fp, live_q.v_sync, live_q.v_bp);
  assign cfg_h_total = sum4(cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp);
  assign cfg_v_total = sum4(cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp);

  // Zero back porch is rejected so the reset position (total-1) always decodes inactive.
  assign cfg_bad = (cfg_h_active == '0) || (cfg_h_sync == '0) || (cfg_h_bp == '0) ||
                   (cfg_v_active == '0) || (cfg_v_sync == '0) || (cfg_v_bp == '0) ||
                   (cfg_h_total > MAX_TOTAL) || (cfg_v_total > MAX_TOTAL);

  assign xw    = TW'(x_q);
  assign yw    = TW'(y_q);
  assign h_end = (xw == h_total - TW'(1));
  assign v_end = (yw == v_total - TW'(1));

  assign hs_start = TW'(live_q.h_active) + TW'(live_q.h_fp);
  assign vs_start = TW'(live_q.v_active) + TW'(live_q.v_fp);
  assign de_raw   = (xw < TW'(live_q.h_active)) && (yw < TW'(live_q.v_active));
  assign hs_raw   = (xw >= hs_start) && (xw < hs_start + TW'(live_q.h_sync));
  assign vs_raw   = (yw >= vs_start) && (yw < vs_start + TW'(live_q.v_sync));

  always_comb begin
    live_d    = live_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    ls_d      = 1'b0;
    fs_d      = 1'b0;
    if (pix_en) begin
      if (h_end) begin
        x_d  = '0;
        ls_d = 1'b1;
        if (v_end) begin
          y_d  = '0;
          fs_d = 1'b1;
          if (pending_q) begin
            live_d    = shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end
    // A load on the wrap cycle lands in the shadow after the old shadow went live.
    if (cfg_load) begin
      if (cfg_bad) begin
        err_d = 1'b1;
      end else begin
        shadow_d  = cfg_in;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q    <= DEFAULTS;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      x_q       <= X_RST;
      y_q       <= Y_RST;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      live_q    <= live_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
    end
  end

  generate
    if (DELAY == 0) begin : g_nodly
      assign de_del = de_raw;
      assign hs_del = hs_raw;
      assign vs_del = vs_raw;
    end else begin : g_dly
      logic [DELAY-1:0] de_pipe_q, de_pipe_d;
      logic [DELAY-1:0] hs_pipe_q, hs_pipe_d;
      logic [DELAY-1:0] vs_pipe_q, vs_pipe_d;

      always_comb begin
        de_pipe_d = de_pipe_q;
        hs_pipe_d = hs_pipe_q;
        vs_pipe_d = vs_pipe_q;
        if (pix_en) begin
          de_pipe_d = (de_pipe_q << 1) | DELAY'(de_raw);
          hs_pipe_d = (hs_pipe_q << 1) | DELAY'(hs_raw);
          vs_pipe_d = (vs_pipe_q << 1) | DELAY'(vs_raw);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          de_pipe_q <= '0;
          hs_pipe_q <= '0;
          vs_pipe_q <= '0;
        end else begin
          de_pipe_q <= de_pipe_d;
          hs_pipe_q <= hs_pipe_d;
          vs_pipe_q <= vs_pipe_d;
        end
      end

      assign de_del = de_pipe_q[DELAY-1];
      assign hs_del = hs_pipe_q[DELAY-1];
      assign vs_del = vs_pipe_q[DELAY-1];
    end
  endgenerate

  assign cfg_pending = pending_q;
  assign cfg_err     = err_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign de          = de_del;
  assign hsync       = hs_del ? HS_LVL : ~HS_LVL;
  assign vsync       = vs_del ? VS_LVL : ~VS_LVL;

endmodule
